id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Registered decode stage with a built-in ID/EX pipeline register. Decodes the IF/ID
//  instruction, reads the register file, and detects load-use hazards against its own
//  issued instruction. Issues one micro-op per cycle to EX with forwarding selects
//  precomputed. Generalises the combinational ID stage: XLEN, register count, handshake,
//  flush, and a stall counter.
// PARAMETERS
//  XLEN    32  datapath width; immediates sign-extend to XLEN
//  REG_AW  5   register address width (2**REG_AW registers, x0 hardwired to 0)
//  CNT_W   16  width of the stall performance counter
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous, active-high reset
//  in_valid        in   1       IF/ID holds a valid instruction
//  in_ready        out  1       ID accepts this cycle (= ~stall)
//  instr           in   32      instruction word
//  pc              in   XLEN    PC of instr
//  flush           in   1       branch/jump redirect: kill the instruction in ID
//  exmem_regWrite  in   1       EX/MEM writes the register file
//  exmem_rd        in   REG_AW  EX/MEM destination register
//  memwb_regWrite  in   1       WB write enable
//  memwb_rd        in   REG_AW  WB destination register
//  wb_data         in   XLEN    WB write data
//  stall           out  1       combinational load-use stall
//  ex_valid        out  1       ID/EX holds a real instruction
//  ex_op           out  7       opcode
//  ex_rd/rs1/rs2   out  REG_AW  register fields
//  ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch  out 1 each
//  ex_alu_op       out  4       ALU operation (package encoding)
//  ex_forwA/B      out  2       00 = regfile, 10 = EX/MEM, 01 = MEM/WB
//  ex_op1/op2      out  XLEN    ALU operands
//  ex_sdata        out  XLEN    store data (rs2 value)
//  ex_pc           out  XLEN    PC of the issued instruction
//  stall_cnt       out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  - Reset: all ex_* outputs 0, ex_valid 0, stall_cnt 0, all registers x1..xN zeroed.
//  - Latency: 1 cycle. instr accepted at edge N appears on ex_* after edge N.
//  - Load-use stall: stall = in_valid & ex_valid & ex_mem_read & ex_rd!=0 &
//    (ex_rd==rs1 | ex_rd==rs2 (rs2 only if opcode uses rs2)). On a stall, ID/EX loads a
//    bubble (ex_valid=0, all control bits 0), in_ready=0, and the instruction is held.
//  - Flush has priority over stall: the ID/EX register loads a bubble, stall is forced
//    to 0, and in_ready=1 so IF can refill.
//  - in_valid=0: ID/EX loads a bubble.
//  - Regfile: written on clk when memwb_regWrite & memwb_rd!=0. The read bypasses
//    write-first: if memwb_rd==rs and a write is occurring, wb_data is read. x0 reads 0.
//  - Forwarding, computed at issue (the ID/EX contents become EX/MEM next cycle):
//    10 if ex_valid & ex_reg_write & ex_rd!=0 & ex_rd==rs;
//    else 01 if exmem_regWrite & exmem_rd!=0 & exmem_rd==rs; else 00.
//  - Operands:
//    op1 = pc for AUIPC/JAL, 0 for LUI, else rs1 data.
//    op2 = immediate for I/load/store/LUI/AUIPC, 4 for JAL/JALR, else rs2 data.
//    U-immediate = {imm20,12'b0} sign-extended to XLEN.
//    Load/JALR take the I-immediate; store takes the S-immediate.
//  - Unknown opcode: issued with all control bits 0 (NOP), ex_valid=1.
//  - stall_cnt increments on each stall cycle and saturates at all-ones.
//  - Reset mid-stall: the ID/EX register is cleared and the stall condition disappears
//    next cycle.
// STRUCTURE
//  - Package id_pkg: opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC),
//    ALU_OP encodings, FWD_* select constants, immediate-extract functions.
//  - Sub-module regfile_bypass_p (XLEN, REG_AW): 2R1W with write-first bypass.
//  - Decode, control and ALU-op generation are inline combinational logic; the ID/EX
//    register is inline.
// TESTING
//  1. rst=1 for 2 cycles -> ex_valid=0, stall_cnt=0; x5 reads 0.
//  2. WB writes x5=0xDEAD_BEEF while ADDI x6,x5,1 is in ID in the same cycle
//     -> ex_op1=0xDEADBEEF, ex_op2=1.
//  3. LW x7,0(x1) then ADD x8,x7,x2 -> stall=1 for one cycle, bubble issued, ADD issues
//     next with ex_forwA=01; stall_cnt=1.
//  4. ADD x3,x1,x2 then SUB x4,x3,x3 -> no stall; SUB has ex_forwA=ex_forwB=10.
//  5. flush=1 during a load-use stall -> bubble issued, stall=0, in_ready=1.
//  6. Writes to x0, LUI x9,0x12345 -> x0 still reads 0; LUI ex_op2=0x12345000, ex_op1=0.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALU operation encodings,
// forwarding selects and raw immediate-field extractors.
package id_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Raw immediates; the stage sign-extends them to its own XLEN.
    function automatic logic [11:0] imm_i(input logic [31:0] instr);
        return instr[31:20];
    endfunction

    function automatic logic [11:0] imm_s(input logic [31:0] instr);
        return {instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic b30,
                                           input logic is_r);
        case (f3)
            3'd0:    return (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return b30 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID handshake and ID/EX issue bundle of the decode stage.
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic              flush;

    logic              ex_valid;
    logic [6:0]        ex_op;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_reg_write;
    logic              ex_jump;
    logic              ex_branch;
    logic [3:0]        ex_alu_op;
    logic [1:0]        ex_forwA;
    logic [1:0]        ex_forwB;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [XLEN-1:0]   ex_sdata;
    logic [XLEN-1:0]   ex_pc;

    modport master (
        output in_valid, instr, pc, flush,
        input  in_ready, ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_jump, ex_branch, ex_alu_op,
               ex_forwA, ex_forwB, ex_op1, ex_op2, ex_sdata, ex_pc
    );

    modport slave (
        input  in_valid, instr, pc, flush,
        output in_ready, ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_jump, ex_branch, ex_alu_op,
               ex_forwA, ex_forwB, ex_op1, ex_op2, ex_sdata, ex_pc
    );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// 2-read / 1-write register file with write-first bypass; x0 is hardwired to zero.
module regfile_bypass_p #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2
);
    localparam int NREG = 2 ** REG_AW;

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != '0);

    // NOTE: the array is cleared by reset because the architecture demands zeroed
    // registers after reset; this prevents mapping it onto a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 :
                      (w_wr && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 :
                      (w_wr && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];
endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: decodes IF/ID, reads the regfile, detects load-use
// hazards against its own issued op and loads the ID/EX register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_pipe_if.slave    bus,
    input  logic              exmem_regWrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regWrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic              valid;
        logic [6:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              jump;
        logic              branch;
        alu_op_e           alu_op;
        logic [1:0]        forw_a;
        logic [1:0]        forw_b;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   sdata;
        logic [XLEN-1:0]   pc;
    } idex_t;

    idex_t             r_idex;
    idex_t             w_dec;
    idex_t             w_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [6:0]        w_opcode;
    logic [2:0]        w_f3;
    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0]   w_rs1_data, w_rs2_data;
    logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_u;
    logic              w_ld_hit;

    assign w_opcode = bus.instr[6:0];
    assign w_f3     = bus.instr[14:12];
    assign w_rd     = bus.instr[7 +: REG_AW];
    assign w_rs1    = bus.instr[15 +: REG_AW];
    assign w_rs2    = bus.instr[20 +: REG_AW];
    assign w_imm_i  = XLEN'($signed(imm_i(bus.instr)));
    assign w_imm_s  = XLEN'($signed(imm_s(bus.instr)));
    assign w_imm_u  = XLEN'($signed(imm_u(bus.instr)));

    regfile_bypass_p #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (memwb_regWrite),
        .i_waddr  (memwb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    // The op now in ID/EX sits in EX/MEM when this one executes, hence the 10 select.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input idex_t ex,
                                           input logic xm_we, input logic [REG_AW-1:0] xm_rd);
        if (ex.valid && ex.reg_write && ex.rd != '0 && ex.rd == rs) return FWD_EXMEM;
        if (xm_we && xm_rd != '0 && xm_rd == rs) return FWD_MEMWB;
        return FWD_RF;
    endfunction

    assign w_ld_hit = r_idex.valid && r_idex.mem_read && (r_idex.rd != '0) &&
                      ((r_idex.rd == w_rs1) || (uses_rs2(w_opcode) && r_idex.rd == w_rs2));
    assign stall        = bus.in_valid && w_ld_hit && !bus.flush;
    assign bus.in_ready = !stall;

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        w_dec           = '0;
        w_dec.valid     = 1'b1;
        w_dec.op        = w_opcode;
        w_dec.rd        = w_rd;
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.alu_op    = ALU_ADD;
        w_dec.forw_a    = fwd_sel(w_rs1, r_idex, exmem_regWrite, exmem_rd);
        w_dec.forw_b    = fwd_sel(w_rs2, r_idex, exmem_regWrite, exmem_rd);
        w_dec.op1       = w_rs1_data;
        w_dec.op2       = w_rs2_data;
        w_dec.sdata     = w_rs2_data;
        w_dec.pc        = bus.pc;
        case (w_opcode)
            OPC_R: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = alu_decode(w_f3, bus.instr[30], 1'b1);
            end
            OPC_I: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = alu_decode(w_f3, bus.instr[30], 1'b0);
                w_dec.op2       = w_imm_i;
            end
            OPC_LOAD: begin
                w_dec.mem_read  = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.op2       = w_imm_i;
            end
            OPC_STORE: begin
                w_dec.mem_write = 1'b1;
                w_dec.op2       = w_imm_s;
            end
            OPC_BRANCH: begin
                w_dec.branch = 1'b1;
                w_dec.alu_op = ALU_SUB;
            end
            OPC_JAL: begin
                w_dec.jump      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.op1       = bus.pc;
                w_dec.op2       = XLEN'(4);
            end
            OPC_JALR: begin
                w_dec.jump      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.op2       = XLEN'(4);
            end
            OPC_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.op1       = '0;
                w_dec.op2       = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.op1       = bus.pc;
                w_dec.op2       = w_imm_u;
            end
            default: ;
        endcase
    end

    assign w_next = (bus.flush || stall || !bus.in_valid) ? idex_t'('0) : w_dec;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_idex <= w_next;
            if (stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt        = r_stall_cnt;
    assign bus.ex_valid     = r_idex.valid;
    assign bus.ex_op        = r_idex.op;
    assign bus.ex_rd        = r_idex.rd;
    assign bus.ex_rs1       = r_idex.rs1;
    assign bus.ex_rs2       = r_idex.rs2;
    assign bus.ex_mem_read  = r_idex.mem_read;
    assign bus.ex_mem_write = r_idex.mem_write;
    assign bus.ex_reg_write = r_idex.reg_write;
    assign bus.ex_jump      = r_idex.jump;
    assign bus.ex_branch    = r_idex.branch;
    assign bus.ex_alu_op    = r_idex.alu_op;
    assign bus.ex_forwA     = r_idex.forw_a;
    assign bus.ex_forwB     = r_idex.forw_b;
    assign bus.ex_op1       = r_idex.op1;
    assign bus.ex_op2       = r_idex.op2;
    assign bus.ex_sdata     = r_idex.sdata;
    assign bus.ex_pc        = r_idex.pc;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: hand-encoded instructions with hand-computed
// expected ID/EX contents, stall behaviour and stall counter saturation.
module tb_id_stage_pipe;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    localparam logic [31:0] I_ADDI_X6_X5_1 = 32'h0012_8313;
    localparam logic [31:0] I_LW_X7_0_X1   = 32'h0000_A383;
    localparam logic [31:0] I_ADD_X8_X7_X2 = 32'h0023_8433;
    localparam logic [31:0] I_ADD_X3_X1_X2 = 32'h0020_81B3;
    localparam logic [31:0] I_SUB_X4_X3_X3 = 32'h4031_8233;
    localparam logic [31:0] I_SW_X2_8_X1   = 32'h0020_A423;
    localparam logic [31:0] I_JAL_X1       = 32'h0000_00EF;
    localparam logic [31:0] I_UNKNOWN      = 32'h0000_007F;
    localparam logic [31:0] I_ADD_X3_X0_X0 = 32'h0000_01B3;
    localparam logic [31:0] I_LUI_X9       = 32'h1234_54B7;

    logic              clk = 1'b0;
    logic              rst;
    logic              exmem_regWrite;
    logic [REG_AW-1:0] exmem_rd;
    logic              memwb_regWrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    id_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .exmem_regWrite (exmem_regWrite),
        .exmem_rd       (exmem_rd),
        .memwb_regWrite (memwb_regWrite),
        .memwb_rd       (memwb_rd),
        .wb_data        (wb_data),
        .stall          (stall),
        .stall_cnt      (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [XLEN-1:0] p);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.pc       = p;
    endtask

    task automatic wb_write(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.in_valid   = 1'b0;
        memwb_regWrite = 1'b1;
        memwb_rd       = rd;
        wb_data        = d;
        tick();
        memwb_regWrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.flush = 1'b0;
        exmem_regWrite = 1'b0; exmem_rd = '0;
        memwb_regWrite = 1'b0; memwb_rd = '0; wb_data = '0;

        // Reset
        tick(); tick();
        check("rst_valid", bus.ex_valid, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_op1", bus.ex_op1, 0);
        check("rst_ready", bus.in_ready, 1);
        rst = 1'b0;
        issue(I_ADDI_X6_X5_1, 32'h10); tick();
        check("x5_zero", bus.ex_op1, 0);
        check("addi_op2", bus.ex_op2, 1);
        check("addi_ctl", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op}, 7'b1100000);
        check("addi_pc", bus.ex_pc, 32'h10);

        // WB write coinciding with the read: write-first bypass
        issue(I_ADDI_X6_X5_1, 32'h14);
        memwb_regWrite = 1'b1; memwb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        memwb_regWrite = 1'b0;
        check("bypass_op1", bus.ex_op1, 32'hDEAD_BEEF);
        check("bypass_op2", bus.ex_op2, 1);
        tick();
        check("stored_op1", bus.ex_op1, 32'hDEAD_BEEF);
        wb_write(5'd1, 32'h100);
        check("idle_bubble", bus.ex_valid, 0);
        wb_write(5'd2, 32'h20);

        // Load-use: one stall cycle, bubble, then ADD with MEM/WB-side forward
        issue(I_LW_X7_0_X1, 32'h20); tick();
        check("lw_ctl", {bus.ex_valid, bus.ex_mem_read, bus.ex_rd}, {2'b11, 5'd7});
        check("lw_op1", bus.ex_op1, 32'h100);
        check("lw_op2", bus.ex_op2, 0);
        issue(I_ADD_X8_X7_X2, 32'h24); #1;
        check("lu_stall", stall, 1);
        check("lu_ready", bus.in_ready, 0);
        tick();
        check("lu_bubble", {bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write}, 0);
        check("lu_cnt", stall_cnt, 1);
        check("lu_stall_gone", stall, 0);
        exmem_regWrite = 1'b1; exmem_rd = 5'd7;
        tick();
        exmem_regWrite = 1'b0; exmem_rd = '0;
        check("lu_add_rd", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd8});
        check("lu_fwdA", bus.ex_forwA, 2'b01);
        check("lu_fwdB", bus.ex_forwB, 2'b00);
        check("lu_add_op2", bus.ex_op2, 32'h20);

        // Back-to-back ALU dependency: forward from EX/MEM, no stall
        issue(I_ADD_X3_X1_X2, 32'h28); tick();
        check("add_ops", {bus.ex_op1, bus.ex_op2}, {32'h100, 32'h20});
        issue(I_SUB_X4_X3_X3, 32'h2C); #1;
        check("sub_nostall", stall, 0);
        tick();
        check("sub_fwd", {bus.ex_forwA, bus.ex_forwB}, 4'b1010);
        check("sub_alu", bus.ex_alu_op, 4'd1);

        // Flush during a load-use stall
        issue(I_LW_X7_0_X1, 32'h30); tick();
        issue(I_ADD_X8_X7_X2, 32'h34); #1;
        check("fl_pre_stall", stall, 1);
        bus.flush = 1'b1; #1;
        check("fl_stall", stall, 0);
        check("fl_ready", bus.in_ready, 1);
        tick();
        bus.flush = 1'b0;
        check("fl_bubble", bus.ex_valid, 0);
        check("fl_cnt", stall_cnt, 1);

        // Store, JAL, unknown opcode
        issue(I_SW_X2_8_X1, 32'h40); tick();
        check("sw_ctl", {bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_read}, 3'b100);
        check("sw_op2", bus.ex_op2, 8);
        check("sw_sdata", bus.ex_sdata, 32'h20);
        issue(I_JAL_X1, 32'h80); tick();
        check("jal_ops", {bus.ex_jump, bus.ex_op1, bus.ex_op2}, {1'b1, 32'h80, 32'h4});
        issue(I_UNKNOWN, 32'h90); tick();
        check("unk_valid", bus.ex_valid, 1);
        check("unk_ctl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                          bus.ex_jump, bus.ex_branch}, 0);

        // x0 writes are ignored; LUI operands
        issue(I_ADD_X3_X0_X0, 32'h50);
        memwb_regWrite = 1'b1; memwb_rd = 5'd0; wb_data = 32'h1234;
        tick();
        memwb_regWrite = 1'b0;
        check("x0_bypass", bus.ex_op1, 0);
        tick();
        check("x0_stored", bus.ex_op1, 0);
        issue(I_LUI_X9, 32'h54); tick();
        check("lui_op2", bus.ex_op2, 32'h1234_5000);
        check("lui_op1", bus.ex_op1, 0);
        check("lui_rd", bus.ex_rd, 9);

        // Stall counter saturates at all-ones
        for (int i = 0; i < 8; i++) begin
            issue(I_LW_X7_0_X1, 32'h100); tick();
            issue(I_ADD_X8_X7_X2, 32'h104); tick();
            check($sformatf("sat_cnt%0d", i), stall_cnt, (i + 2 > 7) ? 7 : i + 2);
            tick();
        end

        // Reset in the middle of a stall
        issue(I_LW_X7_0_X1, 32'h200); tick();
        issue(I_ADD_X8_X7_X2, 32'h204); #1;
        check("rs_pre_stall", stall, 1);
        rst = 1'b1;
        tick();
        check("rs_valid", bus.ex_valid, 0);
        check("rs_stall", stall, 0);
        check("rs_cnt", stall_cnt, 0);
        rst = 1'b0;
        issue(I_ADDI_X6_X5_1, 32'h208); tick();
        check("rs_x5_cleared", bus.ex_op1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
